softmax_row_sched: RTL and testbench
====================================

Name: softmax_row_sched

Overview:
Row-sequencing controller for the safe-softmax unit in the attention path. On a command it walks ROWS score rows out of a row buffer and feeds each row to the softmax unit, holding the level-sensitive start for the whole computation. It collects each result row and writes it out through a valid/ready port. A watchdog aborts the command if the softmax unit stalls.

Parameters:
D_W, 8, word width of each score/probability element (8 or 16).
NUM, 16, words per row; must match the softmax instance.
MAX_ROWS, 64, maximum rows per command.
ADDR_W, $clog2(MAX_ROWS), row address width.
TIMEOUT, 16, cycles allowed in RUN before I_SM_VLD must arrive.

Ports:
I_CLK  in  1  clock.
I_RST  in  1  reset; asynchronous, active-high.
I_CMD_START  in  1  single-cycle command pulse.
I_CMD_ROWS  in  ADDR_W+1  number of rows, 0..MAX_ROWS.
O_BUSY  out  1  high from command accept until return to IDLE.
O_DONE  out  1  single-cycle completion pulse.
O_ERR  out  1  sticky timeout flag.
O_RD_EN  out  1  row buffer read strobe.
O_RD_ADDR  out  ADDR_W  row index being read.
I_RD_DATA  in  D_W x [0:NUM-1]  row data, valid exactly 1 cycle after O_RD_EN.
O_SM_START  out  1  softmax start; level, held during computation.
O_SM_DATA  out  D_W x [0:NUM-1]  latched row to softmax; stable while O_SM_START=1.
I_SM_VLD  in  1  softmax result pulse.
I_SM_DATA  in  D_W x [0:NUM-1]  softmax result, sampled when I_SM_VLD=1.
O_WR_VLD  out  1  result row valid.
O_WR_ADDR  out  ADDR_W  destination row index.
O_WR_DATA  out  D_W x [0:NUM-1]  result row.
I_WR_RDY  in  1  sink ready.

Behaviour:
- Reset (I_RST=1, any cycle, including mid-command): state IDLE. All outputs and data registers are 0. Row counter and watchdog are cleared.
- All outputs are registered.
- States: IDLE, READ, LATCH, RUN, WAIT_OUT, DONE.
- IDLE:
  - I_CMD_START with I_CMD_ROWS=0: go to DONE. No reads are issued.
  - I_CMD_START with I_CMD_ROWS>MAX_ROWS: clamp to MAX_ROWS.
  - Otherwise: latch the row count, set row=0, O_BUSY=1, clear O_ERR, go to READ.
- READ: O_RD_EN=1 for exactly one cycle, O_RD_ADDR=row. Go to LATCH.
- LATCH: capture I_RD_DATA into O_SM_DATA, assert O_SM_START, clear the watchdog. Go to RUN.
- RUN: hold O_SM_START=1 and O_SM_DATA steady.
  - On I_SM_VLD: capture I_SM_DATA into O_WR_DATA, set O_WR_ADDR=row, O_WR_VLD=1, drop O_SM_START. Go to WAIT_OUT.
  - If the watchdog reaches TIMEOUT without I_SM_VLD: drop O_SM_START, set O_ERR=1, go to DONE. The remaining rows are skipped.
- WAIT_OUT: hold O_WR_* until I_WR_RDY=1 while O_WR_VLD=1.
  - On the handshake cycle: drop O_WR_VLD and increment row.
  - If that was the last row, go to DONE; otherwise go to READ.
- DONE: O_DONE=1 for one cycle, O_BUSY=0 next cycle, go to IDLE.
- O_SM_START gap: it must stay low for at least 2 consecutive cycles between rows (READ+LATCH guarantee this). This lets the softmax unit return to its idle state after any spurious restart caused by start being sampled on its valid cycle.
- I_SM_VLD outside RUN is ignored.
- I_CMD_START while O_BUSY=1 is ignored, with no side effects.
- The write port follows the standard valid/ready rule: O_WR_DATA/O_WR_ADDR must not change while O_WR_VLD=1 and I_WR_RDY=0.
- O_ERR holds until the next accepted command or reset.
- Nominal per-row cost is 2 cycles (READ/LATCH), plus softmax latency (about 6 cycles), plus WAIT_OUT (at least 1 cycle).

Decomposition:
- Package softmax_sched_pkg contains:
  - the state enum (one-hot, 6 states);
  - default NUM/D_W/TIMEOUT localparams;
  - a row typedef: logic [D_W-1:0] row_t [0:NUM-1].
- One sub-module, sm_watchdog: a clearable, enabled counter with a parameterised TIMEOUT and a single-cycle expire output. Everything else stays in softmax_row_sched.

Test Plan:
1. Reset mid-RUN:
   - Stimulus: I_RST=1 with O_SM_START=1 and row=2.
   - Required: on the same cycle, all outputs are 0 and the state is IDLE. The next command after release restarts at row 0.
2. Single row:
   - Stimulus: ROWS=1, buffer row0 = 16 x 8'h00; softmax model returns 16 x 8'h10 six cycles after start; I_WR_RDY=1.
   - Required: one write with addr=0 and data=16 x 8'h10, then O_DONE pulses once and O_ERR=0.
3. Four rows with back-pressure:
   - Stimulus: ROWS=4; I_WR_RDY low for 3 cycles on row 1.
   - Required:
     - writes at addr 0,1,2,3 in order;
     - row-1 data held stable during the stall;
     - exactly 4 O_RD_EN pulses;
     - O_SM_START low for at least 2 cycles between rows.
4. Zero rows and busy command:
   - Stimulus: ROWS=0.
   - Required: O_DONE pulses 2 cycles after the command, with no O_RD_EN, O_SM_START or O_WR_VLD activity.
   - Stimulus: a second I_CMD_START during a 3-row run.
   - Required: it is ignored; exactly 3 writes occur.
5. Timeout:
   - Stimulus: the softmax model never asserts I_SM_VLD, ROWS=3.
   - Required: O_SM_START drops after 16 RUN cycles, O_ERR=1, O_DONE pulses, no writes. The next command clears O_ERR.
6. Stray valid:
   - Stimulus: I_SM_VLD pulsed during READ and during WAIT_OUT.
   - Required: no capture, no state change, and the write data is unchanged.

Source files
------------

// File: rtl/softmax_row_sched_pkg.sv
// Shared types for the softmax row scheduler: one-hot state encoding,
// default geometry and the row container used by the datapath.
package softmax_sched_pkg;

  localparam int D_W_DEF     = 8;
  localparam int NUM_DEF     = 16;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_READ     = 6'b000010,
    S_LATCH    = 6'b000100,
    S_RUN      = 6'b001000,
    S_WAIT_OUT = 6'b010000,
    S_DONE     = 6'b100000
  } state_t;

  typedef logic [D_W_DEF-1:0] row_t [0:NUM_DEF-1];

endpackage

// File: rtl/sm_watchdog.sv
// Clearable stall counter; expire is a single-cycle pulse on the enabled
// cycle that completes TIMEOUT counted cycles.
module sm_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_CLR,
  input  logic I_EN,
  output logic O_EXPIRE
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign O_EXPIRE = I_EN && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST)
      cnt <= '0;
    else if (I_CLR)
      cnt <= '0;
    else if (I_EN && !O_EXPIRE)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/softmax_row_sched.sv
// Walks a block of score rows through the softmax unit one row at a time
// and streams each result row out over a valid/ready write port.
module softmax_row_sched
  import softmax_sched_pkg::*;
#(
  parameter int D_W      = D_W_DEF,
  parameter int NUM      = NUM_DEF,
  parameter int MAX_ROWS = 64,
  parameter int ADDR_W   = $clog2(MAX_ROWS),
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_CMD_START,
  input  logic [ADDR_W:0]   I_CMD_ROWS,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERR,
  output logic              O_RD_EN,
  output logic [ADDR_W-1:0] O_RD_ADDR,
  input  logic [D_W-1:0]    I_RD_DATA [0:NUM-1],
  output logic              O_SM_START,
  output logic [D_W-1:0]    O_SM_DATA [0:NUM-1],
  input  logic              I_SM_VLD,
  input  logic [D_W-1:0]    I_SM_DATA [0:NUM-1],
  output logic              O_WR_VLD,
  output logic [ADDR_W-1:0] O_WR_ADDR,
  output logic [D_W-1:0]    O_WR_DATA [0:NUM-1],
  input  logic              I_WR_RDY
);

  localparam logic [ADDR_W:0] ROWS_CAP = MAX_ROWS[ADDR_W:0];

  state_t          state_q, state_nx;
  logic [ADDR_W:0] rows_q, row_q, row_inc, rows_clamped;
  logic            last_row, wd_clr, wd_en, wd_exp;

  assign rows_clamped = (I_CMD_ROWS > ROWS_CAP) ? ROWS_CAP : I_CMD_ROWS;
  assign row_inc      = row_q + 1'b1;
  assign last_row     = (row_inc == rows_q);
  assign wd_clr       = (state_q == S_LATCH);
  assign wd_en        = (state_q == S_RUN);

  sm_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .I_CLK    (I_CLK),
    .I_RST    (I_RST),
    .I_CLR    (wd_clr),
    .I_EN     (wd_en),
    .O_EXPIRE (wd_exp)
  );

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) state_q <= S_IDLE;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:     if (I_CMD_START) state_nx = (I_CMD_ROWS == '0) ? S_DONE : S_READ;
      S_READ:     state_nx = S_LATCH;
      S_LATCH:    state_nx = S_RUN;
      // A result arriving on the expiry cycle still wins over the timeout.
      S_RUN:      if (I_SM_VLD) state_nx = S_WAIT_OUT;
                  else if (wd_exp) state_nx = S_DONE;
      S_WAIT_OUT: if (I_WR_RDY) state_nx = last_row ? S_DONE : S_READ;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Registered outputs and row bookkeeping, updated on the cycle that
  // leaves each state so every output is valid in the state it belongs to.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      rows_q     <= '0;
      row_q      <= '0;
      O_BUSY     <= 1'b0;
      O_DONE     <= 1'b0;
      O_ERR      <= 1'b0;
      O_RD_EN    <= 1'b0;
      O_RD_ADDR  <= '0;
      O_SM_START <= 1'b0;
      O_SM_DATA  <= '{default: '0};
      O_WR_VLD   <= 1'b0;
      O_WR_ADDR  <= '0;
      O_WR_DATA  <= '{default: '0};
    end else begin
      case (state_q)
        S_IDLE: begin
          O_DONE <= 1'b0;
          if (I_CMD_START && (I_CMD_ROWS != '0)) begin
            rows_q    <= rows_clamped;
            row_q     <= '0;
            O_BUSY    <= 1'b1;
            O_ERR     <= 1'b0;
            O_RD_EN   <= 1'b1;
            O_RD_ADDR <= '0;
          end
        end
        S_READ: O_RD_EN <= 1'b0;
        S_LATCH: begin
          O_SM_DATA  <= I_RD_DATA;
          O_SM_START <= 1'b1;
        end
        S_RUN: begin
          if (I_SM_VLD) begin
            O_WR_DATA  <= I_SM_DATA;
            O_WR_ADDR  <= row_q[ADDR_W-1:0];
            O_WR_VLD   <= 1'b1;
            O_SM_START <= 1'b0;
          end else if (wd_exp) begin
            O_SM_START <= 1'b0;
            O_ERR      <= 1'b1;
          end
        end
        S_WAIT_OUT: begin
          if (I_WR_RDY) begin
            O_WR_VLD <= 1'b0;
            row_q    <= row_inc;
            if (!last_row) begin
              O_RD_EN   <= 1'b1;
              O_RD_ADDR <= row_inc[ADDR_W-1:0];
            end
          end
        end
        S_DONE: begin
          O_DONE <= 1'b1;
          O_BUSY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_row_sched.sv
// Bench for softmax_row_sched: row buffer, softmax stand-in and write sink
// are modelled behaviourally; results are checked against a per-row model.
module tb_softmax_row_sched;
  import softmax_sched_pkg::*;

  localparam int D_W      = 8;
  localparam int NUM      = 16;
  localparam int MAX_ROWS = 64;
  localparam int ADDR_W   = $clog2(MAX_ROWS);
  localparam int TIMEOUT  = 16;
  localparam int SM_LAT   = 6;

  typedef logic [D_W*NUM-1:0] flat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_start = 1'b0;
  logic [ADDR_W:0]   cmd_rows = '0;
  logic              busy, done, err, rd_en, sm_start, wr_vld;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  row_t              rd_data = '{default: '0};
  row_t              sm_res  = '{default: '0};
  row_t              sm_data, wr_data;
  logic              sm_vld = 1'b0;
  logic              wr_rdy = 1'b1;

  softmax_row_sched #(
    .D_W(D_W), .NUM(NUM), .MAX_ROWS(MAX_ROWS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .I_CLK(clk), .I_RST(rst), .I_CMD_START(cmd_start), .I_CMD_ROWS(cmd_rows),
    .O_BUSY(busy), .O_DONE(done), .O_ERR(err),
    .O_RD_EN(rd_en), .O_RD_ADDR(rd_addr), .I_RD_DATA(rd_data),
    .O_SM_START(sm_start), .O_SM_DATA(sm_data), .I_SM_VLD(sm_vld), .I_SM_DATA(sm_res),
    .O_WR_VLD(wr_vld), .O_WR_ADDR(wr_addr), .O_WR_DATA(wr_data), .I_WR_RDY(wr_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  int cmp = 0;
  int mis = 0;

  // Configuration written only by the test tasks.
  flat_t mem [0:MAX_ROWS-1];
  bit    sm_en = 1'b1;
  bit    stray_en = 1'b0;
  int    stall_cfg_addr = -1;
  int    stall_cfg_n = 0;

  // Observations written only by the environment process below.
  int    cyc = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, cmd_cyc = 0;
  int    gap_min = 1000, lo_run = 0, sm_hi = 0, last_hi = 0;
  int    instab = 0, wr_act = 0, start_act = 0, stall_left = 0, stall_addr = -1;
  bit    seen_hi = 0, rd_pend = 0, prev_start = 0, prev_wv = 0, prev_rdy = 1;
  logic [ADDR_W-1:0] rd_pend_addr = '0, prev_addr = '0;
  flat_t prev_data = '0, prev_smd = '0;
  logic [ADDR_W-1:0] got_addr [$];
  flat_t             got_data [$];

  function automatic flat_t pack(input row_t r);
    flat_t f;
    for (int i = 0; i < NUM; i++) f[i*D_W +: D_W] = r[i];
    return f;
  endfunction

  function automatic row_t unpack(input flat_t f);
    row_t r;
    for (int i = 0; i < NUM; i++) r[i] = f[i*D_W +: D_W];
    return r;
  endfunction

  function automatic flat_t rnd_flat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in softmax transfer: every element offset by 0x10.
  function automatic flat_t sm_ref(input flat_t x);
    flat_t r;
    for (int i = 0; i < NUM; i++) r[i*D_W +: D_W] = x[i*D_W +: D_W] + 8'h10;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (cmd_start && !busy && !rst) begin
      got_addr.delete(); got_data.delete();
      rd_cnt = 0; gap_min = 1000; seen_hi = 0; instab = 0; wr_act = 0; start_act = 0;
      cmd_cyc = cyc; stall_addr = stall_cfg_addr; stall_left = stall_cfg_n;
    end
    // Row buffer: data valid only on the cycle after the read strobe.
    if (rd_pend) begin
      rd_data = unpack(mem[rd_pend_addr]);
      rd_pend = 0;
    end else rd_data = unpack(rnd_flat());
    if (rd_en) begin
      rd_pend = 1; rd_pend_addr = rd_addr; rd_cnt++;
    end
    if (sm_start) begin
      if (!prev_start) begin
        if (seen_hi && lo_run < gap_min) gap_min = lo_run;
        seen_hi = 1;
      end
      sm_hi++; start_act++;
      if (prev_start && pack(sm_data) !== prev_smd) instab++;
    end else begin
      if (prev_start) last_hi = sm_hi;
      lo_run = prev_start ? 1 : lo_run + 1;
      sm_hi = 0;
    end
    sm_vld = 1'b0;
    sm_res = unpack(rnd_flat());
    if (sm_en && sm_start && sm_hi == SM_LAT) begin
      sm_vld = 1'b1;
      sm_res = unpack(sm_ref(pack(sm_data)));
    end
    if (stray_en && (rd_en || wr_vld)) sm_vld = 1'b1;
    if (wr_vld && stall_left > 0 && int'(wr_addr) == stall_addr) begin
      wr_rdy = 1'b0; stall_left--;
    end else wr_rdy = 1'b1;
    if (prev_wv && !prev_rdy && wr_vld && (wr_addr !== prev_addr || pack(wr_data) !== prev_data))
      instab++;
    if (wr_vld) wr_act++;
    if (wr_vld && wr_rdy) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(pack(wr_data));
    end
    if (done) begin
      done_cnt++; done_cyc = cyc;
    end
    prev_start = sm_start; prev_wv = wr_vld; prev_rdy = wr_rdy;
    prev_addr = wr_addr; prev_data = pack(wr_data); prev_smd = pack(sm_data);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rows);
    cmd_rows  = rows[ADDR_W:0];
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick(); n++;
    end
    tick(2);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < MAX_ROWS; i++) mem[i] = rnd_flat();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    cmp++; if ({busy, done, err, rd_en, sm_start, wr_vld} !== 6'b0) begin
      mis++; $display("FAIL reset_ctrl: got %b required 000000", {busy, done, err, rd_en, sm_start, wr_vld});
    end
    cmp++; if ({rd_addr, wr_addr} !== '0) begin
      mis++; $display("FAIL reset_addr: got %h required 0", {rd_addr, wr_addr});
    end
    cmp++; if ({pack(sm_data), pack(wr_data)} !== '0) begin
      mis++; $display("FAIL reset_data: got %h / %h required 0", pack(sm_data), pack(wr_data));
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_row();
    int d0 = done_cnt;
    flat_t exp = {NUM{8'h10}};
    mem[0] = '0; sm_en = 1'b1; stall_cfg_n = 0;
    issue(1);
    wait_done(d0, 100);
    cmp++; if (done_cnt - d0 != 1) begin
      mis++; $display("FAIL single_done: got %0d pulses required 1", done_cnt - d0);
    end
    cmp++; if (got_addr.size() != 1) begin
      mis++; $display("FAIL single_count: got %0d writes required 1", got_addr.size());
    end
    if (got_addr.size() > 0) begin
      cmp++; if (got_addr[0] !== '0) begin
        mis++; $display("FAIL single_addr: got %0d required 0", got_addr[0]);
      end
      cmp++; if (got_data[0] !== exp) begin
        mis++; $display("FAIL single_data: got %h required %h", got_data[0], exp);
      end
    end
    cmp++; if (err !== 1'b0) begin
      mis++; $display("FAIL single_err: got %b required 0", err);
    end
    cmp++; if (rd_cnt != 1) begin
      mis++; $display("FAIL single_reads: got %0d required 1", rd_cnt);
    end
  endtask

  task automatic test_back_pressure();
    int d0 = done_cnt;
    fill_mem();
    stall_cfg_addr = 1; stall_cfg_n = 3;
    issue(4);
    wait_done(d0, 300);
    stall_cfg_n = 0;
    cmp++; if (done_cnt - d0 != 1) begin
      mis++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt - d0);
    end
    cmp++; if (got_addr.size() != 4) begin
      mis++; $display("FAIL bp_count: got %0d writes required 4", got_addr.size());
    end
    for (int r = 0; r < 4 && r < got_addr.size(); r++) begin
      cmp++; if (got_addr[r] !== r[ADDR_W-1:0] || got_data[r] !== sm_ref(mem[r])) begin
        mis++; $display("FAIL bp_row%0d: got addr %0d data %h required addr %0d data %h",
                        r, got_addr[r], got_data[r], r, sm_ref(mem[r]));
      end
    end
    cmp++; if (instab != 0) begin
      mis++; $display("FAIL bp_stable: got %0d changes under stall required 0", instab);
    end
    cmp++; if (rd_cnt != 4) begin
      mis++; $display("FAIL bp_reads: got %0d required 4", rd_cnt);
    end
    cmp++; if (gap_min < 2 || gap_min == 1000) begin
      mis++; $display("FAIL bp_start_gap: got %0d low cycles required >=2", gap_min);
    end
  endtask

  task automatic test_zero_and_busy();
    int d0 = done_cnt;
    int n = 0;
    issue(0);
    wait_done(d0, 20);
    cmp++; if (done_cnt - d0 != 1) begin
      mis++; $display("FAIL zero_done: got %0d pulses required 1", done_cnt - d0);
    end
    cmp++; if (done_cyc - cmd_cyc != 2) begin
      mis++; $display("FAIL zero_latency: got %0d cycles required 2", done_cyc - cmd_cyc);
    end
    cmp++; if (rd_cnt != 0 || start_act != 0 || wr_act != 0) begin
      mis++; $display("FAIL zero_activity: got rd %0d start %0d wr %0d required 0 0 0", rd_cnt, start_act, wr_act);
    end
    fill_mem();
    d0 = done_cnt;
    issue(3);
    while (got_addr.size() < 1 && n < 100) begin
      tick(); n++;
    end
    issue(5);
    wait_done(d0, 300);
    cmp++; if (done_cnt - d0 != 1) begin
      mis++; $display("FAIL busy_done: got %0d pulses required 1", done_cnt - d0);
    end
    cmp++; if (got_addr.size() != 3 || rd_cnt != 3) begin
      mis++; $display("FAIL busy_count: got %0d writes %0d reads required 3 3", got_addr.size(), rd_cnt);
    end
    for (int r = 0; r < got_addr.size(); r++) begin
      cmp++; if (got_addr[r] !== r[ADDR_W-1:0] || got_data[r] !== sm_ref(mem[r])) begin
        mis++; $display("FAIL busy_row%0d: got addr %0d data %h required data %h", r, got_addr[r], got_data[r], sm_ref(mem[r]));
      end
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    fill_mem();
    sm_en = 1'b0;
    issue(3);
    wait_done(d0, 200);
    sm_en = 1'b1;
    cmp++; if (done_cnt - d0 != 1) begin
      mis++; $display("FAIL to_done: got %0d pulses required 1", done_cnt - d0);
    end
    cmp++; if (last_hi != TIMEOUT) begin
      mis++; $display("FAIL to_start_len: got %0d cycles required %0d", last_hi, TIMEOUT);
    end
    cmp++; if (got_addr.size() != 0 || wr_act != 0 || rd_cnt != 1) begin
      mis++; $display("FAIL to_skip: got %0d writes %0d reads required 0 1", got_addr.size(), rd_cnt);
    end
    tick(3);
    cmp++; if (err !== 1'b1) begin
      mis++; $display("FAIL to_err: got %b required 1", err);
    end
    d0 = done_cnt;
    issue(1);
    wait_done(d0, 100);
    cmp++; if (err !== 1'b0 || got_addr.size() != 1) begin
      mis++; $display("FAIL to_recover: got err %b writes %0d required 0 1", err, got_addr.size());
    end
  endtask

  task automatic test_stray();
    int d0 = done_cnt;
    fill_mem();
    stray_en = 1'b1; stall_cfg_addr = 0; stall_cfg_n = 3;
    issue(2);
    wait_done(d0, 200);
    stray_en = 1'b0; stall_cfg_n = 0;
    cmp++; if (done_cnt - d0 != 1 || got_addr.size() != 2) begin
      mis++; $display("FAIL stray_count: got %0d pulses %0d writes required 1 2", done_cnt - d0, got_addr.size());
    end
    for (int r = 0; r < got_addr.size(); r++) begin
      cmp++; if (got_addr[r] !== r[ADDR_W-1:0] || got_data[r] !== sm_ref(mem[r])) begin
        mis++; $display("FAIL stray_row%0d: got data %h required %h", r, got_data[r], sm_ref(mem[r]));
      end
    end
    cmp++; if (instab != 0) begin
      mis++; $display("FAIL stray_stable: got %0d changes required 0", instab);
    end
  endtask

  task automatic test_clamp();
    int d0 = done_cnt;
    int bad = 0;
    fill_mem();
    issue(100);
    wait_done(d0, 2000);
    cmp++; if (got_addr.size() != MAX_ROWS || rd_cnt != MAX_ROWS) begin
      mis++; $display("FAIL clamp_count: got %0d writes %0d reads required %0d", got_addr.size(), rd_cnt, MAX_ROWS);
    end
    for (int r = 0; r < got_addr.size(); r++)
      if (got_addr[r] !== r[ADDR_W-1:0] || got_data[r] !== sm_ref(mem[r])) bad++;
    cmp++; if (bad != 0) begin
      mis++; $display("FAIL clamp_rows: got %0d wrong rows required 0", bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0 = done_cnt;
    int n = 0;
    fill_mem();
    issue(4);
    while (!(got_addr.size() >= 2 && sm_start) && n < 300) begin
      tick(); n++;
    end
    cmp++; if (!(got_addr.size() >= 2 && sm_start)) begin
      mis++; $display("FAIL mid_reach: got %0d writes start %b required row 2 running", got_addr.size(), sm_start);
    end
    rst = 1'b1;
    #1;
    cmp++; if ({busy, done, err, rd_en, sm_start, wr_vld, rd_addr, wr_addr} !== '0) begin
      mis++; $display("FAIL mid_reset_ctrl: got %h required 0", {busy, done, err, rd_en, sm_start, wr_vld, rd_addr, wr_addr});
    end
    cmp++; if ({pack(sm_data), pack(wr_data)} !== '0) begin
      mis++; $display("FAIL mid_reset_data: got %h / %h required 0", pack(sm_data), pack(wr_data));
    end
    tick();
    rst = 1'b0;
    tick(2);
    d0 = done_cnt;
    issue(2);
    wait_done(d0, 200);
    cmp++; if (done_cnt - d0 != 1 || got_addr.size() != 2) begin
      mis++; $display("FAIL mid_restart: got %0d pulses %0d writes required 1 2", done_cnt - d0, got_addr.size());
    end
    for (int r = 0; r < got_addr.size(); r++) begin
      cmp++; if (got_addr[r] !== r[ADDR_W-1:0] || got_data[r] !== sm_ref(mem[r])) begin
        mis++; $display("FAIL mid_row%0d: got addr %0d data %h required addr %0d", r, got_addr[r], got_data[r], r);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MAX_ROWS; i++) mem[i] = '0;
    test_reset();
    test_single_row();
    test_back_pressure();
    test_zero_and_busy();
    test_timeout();
    test_stray();
    test_clamp();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
